// File: rtl/capture_sequencer.sv
// Frame capture sequencer: a synchronized trigger drives one even/odd ping-pong write frame, then a paced readout.
// Build option: define CAPTURE_RESTART_EN so that a trigger during capture restarts the frame.
module capture_sequencer #(
    parameter int FRAME_LEN = 2176,
    parameter int ADDR_W    = 12,
    parameter int RD_LAT    = 2
) (
    input  logic              ClockFromADC,
    input  logic              Reset,
    input  logic              SynchrM,
    input  logic              Arm,
    input  logic              ReadReady,
    output logic              WriteEnableEven,
    output logic              WriteEnableOdd,
    output logic [ADDR_W-1:0] AddrWrite,
    output logic              ReadEnable,
    output logic [ADDR_W-1:0] AddrRead,
    output logic              ReadBank,
    output logic              DataValid,
    output logic              ReadyBuff,
    output logic              Busy,
    output logic              Overrun,
    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_READOUT = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [RD_LAT-1:0] PIPE_TOP  = RD_LAT'(1) << (RD_LAT - 1);

    logic [1:0]        r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync3;
    logic [2:0]        r_sync_vld;
    logic              r_trig;
    logic              r_wr_odd;
    logic [ADDR_W-1:0] r_addr_wr;
    logic              r_rd_odd;
    logic [ADDR_W-1:0] r_addr_rd;
    logic              r_rd_done;
    logic [RD_LAT-1:0] r_vpipe;
    logic [RD_LAT-1:0] r_bpipe;
    logic              r_overrun;

    logic w_restart;
    logic w_rd_en;
    logic w_last_dv;

`ifdef CAPTURE_RESTART_EN
    assign w_restart = r_trig;
`else
    assign w_restart = 1'b0;
`endif

    // Handshake: one sample moves in every cycle where ReadEnable and ReadReady are both high;
    // ReadEnable is ReadReady gated by "in READOUT with reads remaining", so no read is dropped or repeated.
    assign w_rd_en   = (r_state == ST_READOUT) && !r_rd_done && ReadReady;
    assign w_last_dv = r_rd_done && r_vpipe[RD_LAT-1] && ((r_vpipe & ~PIPE_TOP) == '0);

    assign WriteEnableEven = (r_state == ST_CAPTURE) && !r_wr_odd;
    assign WriteEnableOdd  = (r_state == ST_CAPTURE) && r_wr_odd;
    assign AddrWrite       = r_addr_wr;
    assign ReadEnable      = w_rd_en;
    assign AddrRead        = r_addr_rd;
    assign DataValid       = r_vpipe[RD_LAT-1];
    assign ReadBank        = r_bpipe[RD_LAT-1];
    assign ReadyBuff       = (r_state == ST_READOUT);
    assign Busy            = (r_state != ST_IDLE);
    assign Overrun         = r_overrun;
    assign o_dbg_state     = r_state;

    always_ff @(posedge ClockFromADC) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_sync_vld <= '0;
            r_trig     <= 1'b0;
            r_wr_odd   <= 1'b0;
            r_addr_wr  <= '0;
            r_rd_odd   <= 1'b0;
            r_addr_rd  <= '0;
            r_rd_done  <= 1'b0;
            r_vpipe    <= '0;
            r_bpipe    <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_sync1    <= SynchrM;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            // Edge detection waits until the pipeline holds only post-reset samples,
            // so a level already high at reset release is not mistaken for an edge.
            r_sync_vld <= {r_sync_vld[1:0], 1'b1};
            r_trig     <= r_sync2 && !r_sync3 && r_sync_vld[2];

            r_vpipe[0] <= w_rd_en;
            r_bpipe[0] <= w_rd_en && r_rd_odd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_bpipe[i] <= r_bpipe[i-1];
            end

            case (r_state)
                ST_IDLE: begin
                    if (Arm) begin
                        r_state   <= ST_ARMED;
                        r_overrun <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (r_trig) begin
                        r_state   <= ST_CAPTURE;
                        r_wr_odd  <= 1'b0;
                        r_addr_wr <= '0;
                    end else if (!Arm) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_restart) begin
                        r_wr_odd  <= 1'b0;
                        r_addr_wr <= '0;
                    end else if (r_wr_odd) begin
                        r_wr_odd <= 1'b0;
                        if (r_addr_wr == LAST_ADDR) begin
                            r_state   <= ST_READOUT;
                            r_addr_wr <= '0;
                            r_rd_odd  <= 1'b0;
                            r_addr_rd <= '0;
                            r_rd_done <= 1'b0;
                        end else begin
                            r_addr_wr <= r_addr_wr + 1'b1;
                        end
                    end else begin
                        r_wr_odd <= 1'b1;
                    end
                end
                ST_READOUT: begin
                    if (r_trig) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_rd_en) begin
                        r_rd_odd <= !r_rd_odd;
                        if (r_rd_odd) begin
                            if (r_addr_rd == LAST_ADDR) begin
                                r_rd_done <= 1'b1;
                            end else begin
                                r_addr_rd <= r_addr_rd + 1'b1;
                            end
                        end
                    end
                    if (w_last_dv) begin
                        r_state   <= ST_IDLE;
                        r_addr_rd <= '0;
                        r_rd_odd  <= 1'b0;
                        r_rd_done <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed frames with random ReadReady pacing, checked against
// per-frame event lists built from the frame rules (write order, read pacing, read latency).
module tb_capture_sequencer;

    localparam int FL = 4;
    localparam int AW = 4;
    localparam int RL = 2;

`ifdef CAPTURE_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          synchrm;
    logic          arm;
    logic          ready;
    logic          we_even;
    logic          we_odd;
    logic [AW-1:0] addr_wr;
    logic          re;
    logic [AW-1:0] addr_rd;
    logic          rbank;
    logic          dvalid;
    logic          rbuff;
    logic          busy;
    logic          ovr;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;

    int wr_cyc[$];
    int wr_bank[$];
    int wr_addr[$];
    int re_cyc[$];
    int re_addr[$];
    int dv_cyc[$];
    int dv_bank[$];

    capture_sequencer #(.FRAME_LEN(FL), .ADDR_W(AW), .RD_LAT(RL)) dut (
        .ClockFromADC    (clk),
        .Reset           (rst_n),
        .SynchrM         (synchrm),
        .Arm             (arm),
        .ReadReady       (ready),
        .WriteEnableEven (we_even),
        .WriteEnableOdd  (we_odd),
        .AddrWrite       (addr_wr),
        .ReadEnable      (re),
        .AddrRead        (addr_rd),
        .ReadBank        (rbank),
        .DataValid       (dvalid),
        .ReadyBuff       (rbuff),
        .Busy            (busy),
        .Overrun         (ovr),
        .o_dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Event log, sampled mid-cycle.
    always @(negedge clk) begin
        if (we_even || we_odd) begin
            wr_cyc.push_back(cyc);
            wr_bank.push_back(int'(we_odd));
            wr_addr.push_back(int'(addr_wr));
        end
        if (we_even && we_odd) viol++;
        if (re) begin
            re_cyc.push_back(cyc);
            re_addr.push_back(int'(addr_rd));
            if (!ready) viol++;
        end
        if (dvalid) begin
            dv_cyc.push_back(cyc);
            dv_bank.push_back(int'(rbank));
        end
        if (rbank && !dvalid) viol++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_logs();
        wr_cyc.delete(); wr_bank.delete(); wr_addr.delete();
        re_cyc.delete(); re_addr.delete();
        dv_cyc.delete(); dv_bank.delete();
        viol = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_we_even"}, we_even, 0);
        chk({nm, "_we_odd"}, we_odd, 0);
        chk({nm, "_addr_wr"}, addr_wr, 0);
        chk({nm, "_re"}, re, 0);
        chk({nm, "_addr_rd"}, addr_rd, 0);
        chk({nm, "_rbank"}, rbank, 0);
        chk({nm, "_dvalid"}, dvalid, 0);
        chk({nm, "_rbuff"}, rbuff, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_ovr"}, ovr, 0);
        chk({nm, "_state"}, dbg_state, 0);
    endtask

    // rr_mode: 0 always ready, 1 toggling 1,0,1,0 from readout start, 2 random.
    task automatic do_frame(input int rr_mode, input bit ovr_trig, input bit cap_trig,
                            input bit rst_mid, input string nm);
        int t, w0, r0, base, lr, rst_cyc, c;
        bit done, rst_done;
        int ew_c[$], ew_b[$], ew_a[$];
        int rr_q[$];
        int ed_c[$], ed_b[$];

        clr_logs();
        synchrm = 1'b0;
        ready   = 1'b0;
        arm     = 1'b1;
        step();
        chk({nm, "_armed_state"}, dbg_state, 1);
        chk({nm, "_armed_busy"}, busy, 1);
        chk({nm, "_armed_ovr_clear"}, ovr, 0);

        t  = cyc;
        w0 = t + 4;
        base = w0;
        if (cap_trig && RESTART) begin
            for (int i = 0; i < 5; i++) begin
                ew_c.push_back(w0 + i); ew_b.push_back(i % 2); ew_a.push_back(i / 2);
            end
            base = w0 + 5;
        end
        for (int i = 0; i < 2 * FL; i++) begin
            ew_c.push_back(base + i); ew_b.push_back(i % 2); ew_a.push_back(i / 2);
        end
        r0 = base + 2 * FL;

        done = 1'b0; rst_done = 1'b0; lr = -1; rst_cyc = -1;
        for (int k = 0; k < 300 && !done; k++) begin
            c = cyc;
            if (!rst_mid && lr >= 0 && c == lr + RL + 1) begin
                chk({nm, "_end_state"}, dbg_state, 0);
                chk({nm, "_end_busy"}, busy, 0);
                chk({nm, "_end_rbuff"}, rbuff, 0);
                chk({nm, "_end_ovr"}, ovr, 32'(ovr_trig));
                done = 1'b1;
            end else if (rst_done && c == rst_cyc + 1) begin
                chk_all_zero({nm, "_post_rst"});
                rst_n = 1'b1;
            end else if (rst_done && c == rst_cyc + 12) begin
                chk({nm, "_post_rst_idle"}, dbg_state, 0);
                done = 1'b1;
            end
            if (c == r0) chk({nm, "_readout_rbuff"}, rbuff, 1);
            if (!done) begin
                synchrm = (c == t) || (c == t + 1) ||
                          (cap_trig && (c == w0 + 1 || c == w0 + 2)) ||
                          (ovr_trig && (c == r0 + 1 || c == r0 + 2));
                arm = (c < w0);
                case (rr_mode)
                    0:       ready = 1'b1;
                    1:       ready = (c >= r0) && ((c - r0) % 2 == 0);
                    default: ready = ($urandom_range(0, 3) != 0);
                endcase
                if (rst_mid && !rst_done && re_cyc.size() == 3) begin
                    ready    = 1'b0;
                    rst_n    = 1'b0;
                    rst_cyc  = c;
                    rst_done = 1'b1;
                end
                if (rst_done) ready = 1'b0;
                if (ready && c >= r0 && rr_q.size() < 2 * FL) begin
                    rr_q.push_back(c);
                    if (rr_q.size() == 2 * FL) lr = c;
                end
                step();
            end
        end
        chk({nm, "_completed"}, done, 1);
        ready = 1'b0;
        step();

        for (int i = 0; i < rr_q.size(); i++) begin
            if (!rst_mid || rr_q[i] + RL <= rst_cyc) begin
                ed_c.push_back(rr_q[i] + RL);
                ed_b.push_back(i % 2);
            end
        end

        chk({nm, "_nwr"}, wr_cyc.size(), ew_c.size());
        for (int i = 0; i < ew_c.size() && i < wr_cyc.size(); i++) begin
            chk({nm, "_wr_cyc"}, wr_cyc[i], ew_c[i]);
            chk({nm, "_wr_bank"}, wr_bank[i], ew_b[i]);
            chk({nm, "_wr_addr"}, wr_addr[i], ew_a[i]);
        end
        chk({nm, "_nrd"}, re_cyc.size(), rr_q.size());
        for (int i = 0; i < rr_q.size() && i < re_cyc.size(); i++) begin
            chk({nm, "_rd_cyc"}, re_cyc[i], rr_q[i]);
            chk({nm, "_rd_addr"}, re_addr[i], i / 2);
        end
        chk({nm, "_ndv"}, dv_cyc.size(), ed_c.size());
        for (int i = 0; i < ed_c.size() && i < dv_cyc.size(); i++) begin
            chk({nm, "_dv_cyc"}, dv_cyc[i], ed_c[i]);
            chk({nm, "_dv_bank"}, dv_bank[i], ed_b[i]);
        end
        chk({nm, "_violations"}, viol, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        synchrm = 1'b1;
        arm     = 1'b1;
        ready   = 1'b1;
        repeat (3) step();
        chk_all_zero("reset");

        // Release with SynchrM already high: arming happens but no trigger.
        clr_logs();
        rst_n = 1'b1;
        repeat (12) step();
        chk("stale_level_writes", wr_cyc.size(), 0);
        chk("stale_level_state", dbg_state, 1);
        synchrm = 1'b0;
        arm     = 1'b0;
        ready   = 1'b0;
        repeat (2) step();
        chk("disarm_state", dbg_state, 0);

        // Trigger with Arm low is ignored.
        clr_logs();
        synchrm = 1'b1;
        repeat (2) step();
        synchrm = 1'b0;
        repeat (10) step();
        chk("noarm_writes", wr_cyc.size(), 0);
        chk("noarm_busy", busy, 0);
        chk("noarm_state", dbg_state, 0);

        do_frame(0, 1'b0, 1'b0, 1'b0, "basic");
        do_frame(1, 1'b0, 1'b0, 1'b0, "toggle");
        do_frame(2, 1'b1, 1'b0, 1'b0, "overrun");
        do_frame(2, 1'b0, 1'b0, 1'b0, "after_ovr");
        do_frame(0, 1'b0, 1'b1, 1'b0, "cap_trig");
        do_frame(2, 1'b0, 1'b0, 1'b1, "rst_mid");
        for (int i = 0; i < 4; i++) begin
            do_frame(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 2176: sample pairs per frame (even+odd bank depth).
REQ-002 Parameter ADDR_W, default 12: bank address width; FRAME_LEN SHALL be <= 2^ADDR_W.
REQ-003 Parameter RD_LAT, default 2: RAM read latency, cycles from ReadEnable to data valid.
REQ-004 ClockFromADC  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 Reset  in  1  synchronous, active-low reset.
REQ-006 SynchrM  in  1  asynchronous frame trigger.
REQ-007 Arm  in  1  level; permits arming from IDLE.
REQ-008 ReadReady  in  1  downstream can accept one sample this cycle.
REQ-009 WriteEnableEven, WriteEnableOdd  out  1 each  bank write strobes.
REQ-010 AddrWrite  out  ADDR_W  write address shared by both banks.
REQ-011 ReadEnable  out  1  read strobe to both banks.
REQ-012 AddrRead  out  ADDR_W  read address shared by both banks.
REQ-013 ReadBank  out  1  bank selector for output mux, aligned with DataValid (0=even).
REQ-014 DataValid  out  1  output mux data valid this cycle.
REQ-015 ReadyBuff  out  1  high for the whole READOUT state.
REQ-016 Busy  out  1  high in ARMED, CAPTURE, READOUT.
REQ-017 Overrun  out  1  sticky: trigger arrived while in READOUT.

Function
REQ-018 SynchrM SHALL pass a two-flop synchronizer; trigger = synchronized rising edge, one-cycle pulse, 3 cycles after input edge.
REQ-019 States IDLE, ARMED, CAPTURE, READOUT; one-hot or binary at implementer's choice.
REQ-020 IDLE->ARMED when Arm=1; ARMED->IDLE when Arm=0 and no trigger same cycle.
REQ-021 ARMED->CAPTURE on trigger; first write occurs the cycle after the transition.
REQ-022 CAPTURE: writes alternate even, odd, even, ... one per cycle, starting with even; AddrWrite starts 0 and increments after each odd write.
REQ-023 CAPTURE->READOUT after the odd write at AddrWrite=FRAME_LEN-1; exactly 2*FRAME_LEN writes per frame.
REQ-024 Write strobes SHALL never be high outside CAPTURE; never both high.
REQ-025 READOUT: read order even[0], odd[0], even[1], ...; a read issues (ReadEnable=1) only in cycles where ReadReady=1; AddrRead advances after each odd read.
REQ-026 DataValid SHALL assert exactly RD_LAT cycles after each ReadEnable, with ReadBank matching that read; reads are never dropped or repeated.
REQ-027 READOUT->IDLE RD_LAT cycles after the final odd read (last DataValid delivered), total 2*FRAME_LEN DataValid pulses.
REQ-028 Trigger in IDLE or READOUT SHALL be ignored for sequencing; trigger in READOUT sets Overrun.
REQ-029 Overrun clears only on reset or on IDLE->ARMED transition.
REQ-030 Trigger during CAPTURE: behaviour per REQ-035/036.
REQ-031 Address counters SHALL not exceed FRAME_LEN-1; no wrap within a frame.

Reset
REQ-032 Reset=0 at a rising edge: state IDLE, synchronizer flops 0, AddrWrite=0, AddrRead=0, all strobes, DataValid, ReadBank, ReadyBuff, Busy, Overrun = 0.
REQ-033 Reset mid-CAPTURE or mid-READOUT SHALL abort the frame immediately; in-flight read-latency pipeline SHALL be flushed (no DataValid after reset).
REQ-034 After reset release a trigger requires fresh arming; a SynchrM level already high SHALL not produce a trigger.

Configuration
REQ-035 Macro CAPTURE_RESTART_EN defined: trigger in CAPTURE restarts the frame -- AddrWrite=0, next write even, state stays CAPTURE.
REQ-036 Macro CAPTURE_RESTART_EN undefined: trigger in CAPTURE is ignored and the frame completes normally.

Verification
REQ-037 FRAME_LEN=4, Arm=1, one SynchrM pulse, ReadReady=1 -> 8 writes even/odd at addr 0,0,1,1,2,2,3,3, then 8 DataValid pulses, ReadBank 0,1,0,1..., state IDLE.
REQ-038 ReadReady toggling 1,0,1,0 in READOUT -> ReadEnable only in ReadReady=1 cycles, 8 DataValid total, each RD_LAT=2 after its read.
REQ-039 Trigger during READOUT -> Overrun=1, readout unaffected; next Arm clears Overrun.
REQ-040 Trigger after 5th write of FRAME_LEN=4 -> with CAPTURE_RESTART_EN: AddrWrite back to 0, 8 further writes; without: 8 writes total.
REQ-041 Reset=0 for one cycle during READOUT after 3 reads -> next cycle all outputs 0, state IDLE, no further DataValid.
REQ-042 Arm=0 with SynchrM pulse -> no write strobes, Busy=0.
